l1_dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate L1 data cache for the pipelined LC-3b core. It sits between the MEM stage and the L2 / physical-memory port. It consumes the MEM stage's mem_read, mem_write and mem_wmask plus the address and store data, and stalls the pipeline until mem_resp. It holds 8 lines of 128 bits (8 words) and fills or evicts whole lines over a 128-bit port.

---
 rtl/l1_dcache_ctrl_pkg.sv | 33 +++
 rtl/l1_array.sv | 43 ++++
 rtl/l1_dcache_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/l1_dcache_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3b_types : shared L1 data-cache types and byte-merge helper      |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package lc3b_types;

   localparam int L1_LINES = 8;

   typedef logic [15:0]  lc3b_word;
   typedef logic [8:0]   lc3b_l1_tag;
   typedef logic [2:0]   lc3b_l1_index;
   typedef logic [2:0]   lc3b_l1_offset;
   typedef logic [127:0] lc3b_l1_line;
   typedef logic [1:0]   lc3b_mem_wmask;

   typedef enum logic [1:0] {
      s_idle      = 2'd0,
      s_writeback = 2'd1,
      s_allocate  = 2'd2
   } lc3b_l1_state;

   function automatic lc3b_word merge_bytes(input lc3b_word old_word,
                                            input lc3b_word new_word,
                                            input lc3b_mem_wmask wmask);
      lc3b_word res;
      res[7:0]  = wmask[0] ? new_word[7:0]  : old_word[7:0];
      res[15:8] = wmask[1] ? new_word[15:8] : old_word[15:8];
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/l1_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_array : 8-entry storage, sync write, comb read, optional reset  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module l1_array
   import lc3b_types::*;
#(
   parameter int WIDTH    = 1,
   parameter bit RESET_EN = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  lc3b_l1_index       index,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout
);

   logic [WIDTH-1:0] mem_q [L1_LINES];

   generate
      if (RESET_EN) begin : g_reset
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < L1_LINES; i++) mem_q[i] <= '0;
            end else if (load) begin
               mem_q[index] <= din;
            end
         end
      end else begin : g_no_reset
         logic rst_unused;
         assign rst_unused = rst;
         always_ff @(posedge clk) begin
            if (load) mem_q[index] <= din;
         end
      end
   endgenerate

   assign dout = mem_q[index];

endmodule
`default_nettype wire

// File: rtl/l1_dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_dcache_ctrl : direct-mapped write-back write-allocate L1 D$     |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module l1_dcache_ctrl
   import lc3b_types::*;
(
   input  logic          clk,
   input  logic          rst,
   input  lc3b_word      mem_address,
   input  logic          mem_read,
   input  logic          mem_write,
   input  lc3b_mem_wmask mem_wmask,
   input  lc3b_word      mem_wdata,
   output lc3b_word      mem_rdata,
   output logic          mem_resp,
   output lc3b_word      pmem_address,
   output logic          pmem_read,
   output logic          pmem_write,
   output lc3b_l1_line   pmem_wdata,
   input  lc3b_l1_line   pmem_rdata,
   input  logic          pmem_resp
);

   lc3b_l1_state  state_q, state_d;
   logic          pmem_read_q, pmem_read_d;
   logic          pmem_write_q, pmem_write_d;

   lc3b_l1_tag    tag, tag_out;
   lc3b_l1_index  index;
   lc3b_l1_offset offset;
   logic [6:0]    word_lsb;
   logic          addr_unused;
   logic          valid_out, dirty_out;
   lc3b_l1_line   data_out, data_in, merged_line;
   logic          req, hit, fill, wr_hit;

   assign tag         = mem_address[15:7];
   assign index       = mem_address[6:4];
   assign offset      = mem_address[3:1];
   assign addr_unused = mem_address[0];
   assign word_lsb    = {offset, 4'b0000};

   assign req      = mem_read | mem_write;
   assign hit      = valid_out && (tag_out == tag);
   assign mem_resp = (state_q == s_idle) && req && hit;
   // Array writes are suppressed during rst so an aborted fill cannot land.
   assign fill     = (state_q == s_allocate) && pmem_resp && !rst;
   assign wr_hit   = mem_resp && mem_write && !rst;

   always_comb begin
      merged_line = data_out;
      merged_line[word_lsb +: 16] = merge_bytes(data_out[word_lsb +: 16], mem_wdata, mem_wmask);
   end

   assign data_in = fill ? pmem_rdata : merged_line;

   l1_array #(.WIDTH(1), .RESET_EN(1'b1)) u_valid (
      .clk(clk), .rst(rst), .load(fill), .index(index), .din(1'b1), .dout(valid_out));

   l1_array #(.WIDTH(1), .RESET_EN(1'b1)) u_dirty (
      .clk(clk), .rst(rst), .load(fill | wr_hit), .index(index), .din(wr_hit), .dout(dirty_out));

   l1_array #(.WIDTH(9), .RESET_EN(1'b0)) u_tag (
      .clk(clk), .rst(rst), .load(fill), .index(index), .din(tag), .dout(tag_out));

   l1_array #(.WIDTH(128), .RESET_EN(1'b0)) u_data (
      .clk(clk), .rst(rst), .load(fill | wr_hit), .index(index), .din(data_in), .dout(data_out));

   always_comb begin
      state_d = state_q;
      case (state_q)
         s_idle: begin
            if (req && !hit) state_d = (valid_out && dirty_out) ? s_writeback : s_allocate;
         end
         s_writeback: if (pmem_resp) state_d = s_allocate;
         s_allocate:  if (pmem_resp) state_d = s_idle;
         default:     state_d = s_idle;
      endcase
      pmem_read_d  = (state_d == s_allocate);
      pmem_write_d = (state_d == s_writeback);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= s_idle;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
      end
   end

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = (state_q == s_writeback) ? {tag_out, index, 4'b0000}
                                                  : {tag, index, 4'b0000};
   assign pmem_wdata   = data_out;
   assign mem_rdata    = data_out[word_lsb +: 16];

endmodule
`default_nettype wire
